// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and sizing helpers for the Booth multiplier
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } booth_state_t;

  localparam int BOOTH_DW_DEFAULT = 5;

  // Step-counter width for the default operand width
  localparam int CNT_W = $clog2(BOOTH_DW_DEFAULT + 1);

  function automatic int booth_cnt_w(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational radix-2 Booth step (add/sub then arithmetic shift)
module booth_step
  import booth_pkg::*;
#(
  parameter int DW = BOOTH_DW_DEFAULT
) (
  input  logic [DW:0]   i_a,
  input  logic [DW-1:0] i_q,
  input  logic          i_q1,
  input  logic [DW:0]   i_m,
  output logic [DW:0]   o_a,
  output logic [DW-1:0] o_q,
  output logic          o_q1
);

  logic [DW:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + i_m;
      2'b10:   w_sum = i_a - i_m;
      default: w_sum = i_a;
    endcase
  end

  // Shift {A,Q,Q-1} right by one, replicating the sign of the extended accumulator
  assign o_a  = {w_sum[DW], w_sum[DW:1]};
  assign o_q  = {w_sum[0], i_q[DW-1:1]};
  assign o_q1 = i_q[0];

endmodule

// File: rtl/booth_multiplier.sv
// rtl/booth_multiplier.sv - sequential signed Booth multiplier; BOOTH_ZERO_SKIP_EN enables zero-operand shortcut
module booth_multiplier
  import booth_pkg::*;
#(
  parameter int DW = BOOTH_DW_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [DW-1:0]   i_multiplicand,
  input  logic [DW-1:0]   i_multiplier,
  output logic [2*DW-1:0] o_product,
  output logic            o_ready,
  output logic            o_done
);

  localparam int            CW        = booth_cnt_w(DW);
  localparam logic [CW-1:0] LAST_STEP = CW'(DW - 1);

  booth_state_t  r_state;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW:0]   r_a;
  logic [DW:0]   r_m;
  logic [DW-1:0] r_q;
  logic          r_q1;
  logic [CW-1:0] r_cnt;

  logic [DW:0]   w_a;
  logic [DW-1:0] w_q;
  logic          w_q1;
  logic          w_zero_skip;

`ifdef BOOTH_ZERO_SKIP_EN
  assign w_zero_skip = (r_mcand == '0) || (r_mplier == '0);
`else
  assign w_zero_skip = 1'b0;
`endif

  booth_step #(
    .DW(DW)
  ) u_step (
    .i_a (r_a),
    .i_q (r_q),
    .i_q1(r_q1),
    .i_m (r_m),
    .o_a (w_a),
    .o_q (w_q),
    .o_q1(w_q1)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_a       <= '0;
      r_m       <= '0;
      r_q       <= '0;
      r_q1      <= 1'b0;
      r_cnt     <= '0;
      o_product <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
            r_state  <= LOAD;
            o_ready  <= 1'b0;
          end
        end
        LOAD: begin
          r_a   <= '0;
          r_q   <= r_mplier;
          r_q1  <= 1'b0;
          r_m   <= {r_mcand[DW-1], r_mcand};
          r_cnt <= '0;
          if (w_zero_skip) begin
            r_state   <= DONE;
            o_product <= '0;
            o_done    <= 1'b1;
          end else begin
            r_state <= CALC;
          end
        end
        CALC: begin
          r_a   <= w_a;
          r_q   <= w_q;
          r_q1  <= w_q1;
          r_cnt <= r_cnt + 1'b1;
          // The final step's result is registered directly so it is visible in DONE
          if (r_cnt == LAST_STEP) begin
            r_state   <= DONE;
            o_product <= {w_a[DW-1:0], w_q};
            o_done    <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          o_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// tb/tb_booth_multiplier.sv - randomized self-checking bench for booth_multiplier
module tb_booth_multiplier;

  localparam int DW = 5;
  localparam int PW = 2 * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [PW-1:0] product;
  logic          ready;
  logic          done;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  booth_multiplier #(
    .DW(DW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .i_multiplicand(mcand),
    .i_multiplier  (mplier),
    .o_product     (product),
    .o_ready       (ready),
    .o_done        (done)
  );

  function automatic logic [PW-1:0] ref_product(input logic [DW-1:0] m, input logic [DW-1:0] q);
    int          mi;
    int          qi;
    logic [31:0] p;
    mi = $signed(m);
    qi = $signed(q);
    p  = mi * qi;
    return p[PW-1:0];
  endfunction

  function automatic int ref_latency(input logic [DW-1:0] m, input logic [DW-1:0] q);
`ifdef BOOTH_ZERO_SKIP_EN
    if (m == '0 || q == '0) return 2;
`endif
    return DW + 2;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
  task automatic run_op(input logic [DW-1:0] m, input logic [DW-1:0] q, input int glitch_k,
                        input string tag);
    int            lat;
    logic [PW-1:0] exp_p;
    logic [31:0]   r;
    lat    = ref_latency(m, q);
    exp_p  = ref_product(m, q);
    mcand  = m;
    mplier = q;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    r      = $urandom;
    mcand  = r[DW-1:0];
    mplier = r[PW-1:DW];
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      check_val({tag, "/ready"}, 64'(ready), 64'(k > lat));
      check_val({tag, "/done"}, 64'(done), 64'(k == lat));
      if (k == lat) check_val({tag, "/product"}, 64'(product), 64'(exp_p));
      if (k == glitch_k) begin
        start  = 1'b1;
        mcand  = 5'd3;
        mplier = 5'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int          dones;
    int          gap;
    logic [31:0] r;
    logic [DW-1:0] rm;
    logic [DW-1:0] rq;

    rst    = 1'b0;
    start  = 1'b0;
    mcand  = '0;
    mplier = '0;
    repeat (2) @(negedge clk);
    check_val("reset/product", 64'(product), 64'd0);
    check_val("reset/ready", 64'(ready), 64'd1);
    check_val("reset/done", 64'(done), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    run_op(5'd7, 5'b11101, 0, "7x-3");
    check_val("7x-3/const", 64'(product), 64'h3EB);
    run_op(5'b10000, 5'b10000, 0, "-16x-16");
    check_val("-16x-16/const", 64'(product), 64'h100);
    run_op(5'b10000, 5'd15, 0, "-16x15");
    run_op(5'd15, 5'b10000, 0, "15x-16");
    run_op(5'd0, 5'd9, 0, "0x9");
    run_op(5'd9, 5'd0, 0, "9x0");
    run_op(5'd5, 5'd6, 3, "5x6_glitch");
    check_val("5x6_glitch/const", 64'(product), 64'd30);

    // Reset in the middle of a calculation
    mcand  = 5'd7;
    mplier = 5'd7;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst/product", 64'(product), 64'd0);
    check_val("midrst/ready", 64'(ready), 64'd1);
    check_val("midrst/done", 64'(done), 64'd0);
    @(negedge clk);
    rst   = 1'b1;
    dones = 0;
    for (int c = 0; c < DW + 3; c++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check_val("midrst/no_done", 64'(dones), 64'd0);
    check_val("midrst/idle_ready", 64'(ready), 64'd1);
    run_op(5'd2, 5'b11110, 0, "2x-2");

    // Start held high across DONE -> IDLE
    mcand  = 5'd3;
    mplier = 5'b11011;
    start  = 1'b1;
    for (int c = 0; c < 4 * DW && !done; c++) @(negedge clk);
    check_val("b2b/first_done", 64'(done), 64'd1);
    check_val("b2b/first_product", 64'(product), 64'(ref_product(5'd3, 5'b11011)));
    mcand  = 5'd6;
    mplier = 5'b11001;
    gap    = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (!done && gap <= 4 * DW);
    start = 1'b0;
    check_val("b2b/gap", 64'(gap), 64'(DW + 3));
    check_val("b2b/second_product", 64'(product), 64'(ref_product(5'd6, 5'b11001)));
    repeat (2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      r  = $urandom;
      rm = r[DW-1:0];
      rq = r[PW-1:DW];
      if (r[12:10] == 3'd0) rm = '0;
      if (r[15:13] == 3'd0) rq = '0;
      run_op(rm, rq, (r[16]) ? 2 + int'(r[18:17]) : 0, "random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
